// File: rtl/addsub_pkg.sv
// Shared types and helpers for the add/sub arbiter slice.
package addsub_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  localparam logic ADD_OP = 1'b1;
  localparam logic SUB_OP = 1'b0;

  function automatic int result_width(input int width);
    return width + 32'sd1;
  endfunction

endpackage

// File: rtl/addsub_ce.sv
// Registered add/subtract unit: captures a result whenever ce is high, holds it otherwise.
module addsub_ce
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             add_sub,
  output logic [WIDTH:0]   result
);

  localparam int RW = result_width(WIDTH);

  logic [RW-1:0] a_ext_s;
  logic [RW-1:0] b_ext_s;

  assign a_ext_s = {1'b0, a};
  assign b_ext_s = {1'b0, b};

  // Result register; subtraction wraps modulo 2^RW so the top bit flags A<B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
    end else if (ce) begin
      result <= (add_sub == ADD_OP) ? (a_ext_s + b_ext_s) : (a_ext_s - b_ext_s);
    end else begin
      result <= result;
    end
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one registered add/sub unit between N_REQ requesters,
// returning results over a valid/ready response port.
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ-1:0]       req_add_sub,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH:0]         rsp_result,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   busy
);

  state_t          state_r;
  logic [ID_W-1:0] ptr_r;
  logic [ID_W-1:0] grant_id_s;
  logic [ID_W-1:0] next_ptr_s;
  logic            found_s;
  logic            accept_s;
  logic [WIDTH-1:0] a_sel_s;
  logic [WIDTH-1:0] b_sel_s;
  logic            op_sel_s;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    s = (s >= N_REQ) ? (s - N_REQ) : s;
    return ID_W'(s);
  endfunction

  // Circular search from ptr_r; the first valid requester wins.
  always_comb begin
    found_s    = 1'b0;
    grant_id_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      grant_id_s = (!found_s && req_valid[wrap_idx(ptr_r, k)]) ? wrap_idx(ptr_r, k) : grant_id_s;
      found_s    = found_s | req_valid[wrap_idx(ptr_r, k)];
    end
  end

  // Gated by rst_n so no grant can leak out while reset is held.
  assign accept_s   = rst_n && found_s && ((state_r == ST_IDLE) || rsp_ready);
  assign next_ptr_s = (grant_id_s == ID_W'(N_REQ - 1)) ? '0 : (grant_id_s + ID_W'(32'd1));

  // Grant vector and operand mux for the winning requester.
  always_comb begin
    req_ready = '0;
    a_sel_s   = '0;
    b_sel_s   = '0;
    op_sel_s  = SUB_OP;
    for (int k = 0; k < N_REQ; k++) begin
      req_ready[k] = accept_s && (grant_id_s == ID_W'(k));
      a_sel_s      = (grant_id_s == ID_W'(k)) ? req_a[k*WIDTH +: WIDTH] : a_sel_s;
      b_sel_s      = (grant_id_s == ID_W'(k)) ? req_b[k*WIDTH +: WIDTH] : b_sel_s;
      op_sel_s     = (grant_id_s == ID_W'(k)) ? req_add_sub[k] : op_sel_s;
    end
  end

  // FSM, rotation pointer and response ID, all advancing on an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ptr_r   <= '0;
      rsp_id  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: state_r <= accept_s ? ST_RESP : ST_IDLE;
        ST_RESP: state_r <= (rsp_ready && !accept_s) ? ST_IDLE : ST_RESP;
        default: state_r <= ST_IDLE;
      endcase
      if (accept_s) begin
        ptr_r  <= next_ptr_s;
        rsp_id <= grant_id_s;
      end else begin
        ptr_r  <= ptr_r;
        rsp_id <= rsp_id;
      end
    end
  end

  assign rsp_valid = (state_r == ST_RESP);
  assign busy      = (state_r != ST_IDLE);

  addsub_ce #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk    (clk),
    .rst_n  (rst_n),
    .ce     (accept_s),
    .a      (a_sel_s),
    .b      (b_sel_s),
    .add_sub(op_sel_s),
    .result (rsp_result)
  );

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_addsub_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int ID_W  = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       req_add_sub;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [WIDTH:0]         rsp_result;
  logic [ID_W-1:0]        rsp_id;
  logic                   busy;

  int checks = 0;
  int errors = 0;
  int last_res;
  int last_id;

  always #5 clk = ~clk;

  addsub_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_add_sub(req_add_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_id(rsp_id), .busy(busy)
  );

  function automatic int ref_op(int a, int b, bit add);
    if (add) return a + b;
    else return (a - b + 512) % 512;
  endfunction

  task automatic set_req(int i, int a, int b, bit add);
    req_valid[i] = 1'b1;
    req_a[i*WIDTH +: WIDTH] = a[7:0];
    req_b[i*WIDTH +: WIDTH] = b[7:0];
    req_add_sub[i] = add;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_result !== 9'd0) begin errors++; $display("FAIL reset_rsp_result got %0d exp 0", rsp_result); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got %0d exp 0", rsp_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = '0;
  endtask

  task automatic test_add();
    req_valid = '0;
    rsp_ready = 1'b1;
    set_req(2, 200, 100, 1'b1);
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL add_grant got %b exp 0100", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_busy_idle got %b exp 0", busy); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_rsp_valid got %b exp 1", rsp_valid); end
    checks++; if (rsp_result !== 9'd300) begin errors++; $display("FAIL add_result got %0d exp 300", rsp_result); end
    checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL add_id got %0d exp 2", rsp_id); end
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL add_return_idle got valid=%b busy=%b exp 0 0", rsp_valid, busy); end
  endtask

  task automatic test_sub();
    @(negedge clk);
    req_valid = '0;
    set_req(0, 5, 10, 1'b0);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL sub_grant got %b exp 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    set_req(0, 255, 0, 1'b0);
    #1;
    checks++; if (rsp_result !== 9'h1FB) begin errors++; $display("FAIL sub_neg_result got %h exp 1fb", rsp_result); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL sub_id got %0d exp 0", rsp_id); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL sub_b2b_grant got %b exp 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (rsp_result !== 9'd255 || rsp_valid !== 1'b1) begin errors++; $display("FAIL sub_255_result got %0d valid=%b exp 255 1", rsp_result, rsp_valid); end
    @(negedge clk);
  endtask

  task automatic test_rotation();
    int a, b, g, cur_res;
    bit op;
    logic [3:0] exp_rdy;
    reset_pulse();
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      g = k % N_REQ;
      cur_res = 0;
      for (int i = 0; i < N_REQ; i++) begin
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
        op = 1'($urandom_range(0, 1));
        set_req(i, a, b, op);
        if (i == g) cur_res = ref_op(a, b, op);
      end
      exp_rdy = 4'b0001 << g;
      #1;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rot_grant k=%0d got %b exp %b", k, req_ready, exp_rdy); end
      if (k > 0) begin
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rot_valid k=%0d got %b exp 1", k, rsp_valid); end
        checks++; if (rsp_id !== 2'(last_id)) begin errors++; $display("FAIL rot_id k=%0d got %0d exp %0d", k, rsp_id, last_id); end
        checks++; if (rsp_result !== 9'(last_res)) begin errors++; $display("FAIL rot_result k=%0d got %0d exp %0d", k, rsp_result, last_res); end
      end
      last_res = cur_res;
      last_id = g;
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int a, b, exp2;
    bit op;
    a = $urandom_range(0, 255);
    b = $urandom_range(0, 255);
    op = 1'($urandom_range(0, 1));
    exp2 = ref_op(a, b, op);
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    set_req(2, a, b, op);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_no_grant c=%0d got %b exp 0000", c, req_ready); end
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(last_id)) begin errors++; $display("FAIL bp_hold_id c=%0d got valid=%b id=%0d exp 1 %0d", c, rsp_valid, rsp_id, last_id); end
      checks++; if (rsp_result !== 9'(last_res)) begin errors++; $display("FAIL bp_hold_result c=%0d got %0d exp %0d", c, rsp_result, last_res); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_grant got %b exp 0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (rsp_id !== 2'd2 || rsp_result !== 9'(exp2)) begin errors++; $display("FAIL bp_next_result got id=%0d res=%0d exp 2 %0d", rsp_id, rsp_result, exp2); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int a, b, exp3;
    a = $urandom_range(0, 255);
    b = $urandom_range(0, 255);
    exp3 = ref_op(a, b, 1'b1);
    req_valid = '0;
    set_req(3, a, b, 1'b1);
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 9'(exp3)) begin errors++; $display("FAIL mid_pre_valid got valid=%b res=%0d exp 1 %0d", rsp_valid, rsp_result, exp3); end
    rst_n = 1'b0;
    req_valid = 4'hF;
    #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got valid=%b busy=%b exp 0 0", rsp_valid, busy); end
    checks++; if (rsp_result !== 9'd0 || rsp_id !== 2'd0) begin errors++; $display("FAIL mid_rst_data got res=%0d id=%0d exp 0 0", rsp_result, rsp_id); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready got %b exp 0000", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant got %b exp 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (rsp_id !== 2'd0 || rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_first_id got id=%0d valid=%b exp 0 1", rsp_id, rsp_valid); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int m_ptr, m_res, m_id, g, idx, dut_acc, dut_rsp, m_acc;
    bit m_pending;
    int av[N_REQ];
    int bv[N_REQ];
    bit ov[N_REQ];
    logic [3:0] exp_rdy;
    reset_pulse();
    m_ptr = 0; m_pending = 1'b0; m_res = 0; m_id = 0;
    dut_acc = 0; dut_rsp = 0; m_acc = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      req_valid = '0;
      for (int i = 0; i < N_REQ; i++) begin
        av[i] = $urandom_range(0, 255);
        bv[i] = $urandom_range(0, 255);
        ov[i] = 1'($urandom_range(0, 1));
        set_req(i, av[i], bv[i], ov[i]);
        req_valid[i] = ($urandom_range(0, 2) == 0);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      g = -1;
      if (!m_pending || rsp_ready) begin
        for (int o = 0; o < N_REQ; o++) begin
          idx = (m_ptr + o) % N_REQ;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      #1;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rnd_grant cyc=%0d got %b exp %b", cyc, req_ready, exp_rdy); end
      checks++; if (!$onehot0(req_ready) || ((req_ready & ~req_valid) != 4'b0000)) begin errors++; $display("FAIL rnd_ready_prop cyc=%0d got ready=%b valid=%b", cyc, req_ready, req_valid); end
      checks++; if (rsp_valid !== m_pending || busy !== m_pending) begin errors++; $display("FAIL rnd_valid cyc=%0d got %b exp %b", cyc, rsp_valid, m_pending); end
      if (m_pending) begin
        checks++; if (rsp_result !== 9'(m_res) || rsp_id !== 2'(m_id)) begin errors++; $display("FAIL rnd_result cyc=%0d got %0d/%0d exp %0d/%0d", cyc, rsp_result, rsp_id, m_res, m_id); end
      end
      if (req_ready != 4'b0000) dut_acc++;
      if (rsp_valid && rsp_ready) dut_rsp++;
      @(posedge clk);
      if (g >= 0) begin
        m_pending = 1'b1;
        m_res = ref_op(av[g], bv[g], ov[g]);
        m_id = g;
        m_ptr = (g + 1) % N_REQ;
        m_acc++;
      end else if (rsp_ready) begin
        m_pending = 1'b0;
      end
      @(negedge clk);
    end
    #1;
    checks++; if (dut_acc !== dut_rsp + (rsp_valid ? 1 : 0)) begin errors++; $display("FAIL rnd_accept_count got acc=%0d rsp=%0d pend=%b", dut_acc, dut_rsp, rsp_valid); end
    checks++; if (dut_acc !== m_acc) begin errors++; $display("FAIL rnd_model_accepts got %0d exp %0d", dut_acc, m_acc); end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_add_sub = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_rotation();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
